seq_det_param: RTL

Parametrised serial pattern detector; next generation of the fixed-pattern 1001 Moore detector.
- Pattern length, reset pattern and overlap mode set at elaboration.
- Pattern reloadable at run time.
- Input qualified by a valid strobe.
- Saturating match counter.
Sits between a serial bit source (deserialiser or line decoder) and control logic that needs a one-cycle detect pulse and a hit count.

---
 rtl/seq_det_param.sv | 137 +++++++++++++
 1 files changed

// File: rtl/seq_det_param.sv
// seq_det_param: parametrised serial pattern detector.
//
// Shifts qualified serial bits into a PAT_LEN-bit history (newest bit at LSB) and raises a
// registered one-cycle pulse on the cycle after the sample that completes the pattern. It also
// keeps a saturating count of matches. The pattern can be reloaded at run time. OVERLAP selects
// whether a match may reuse bits of the previous match.
//
// Optional feature macro: SEQ_DET_MASK_EN. When it is defined, the design adds the patMaskIn
// port and a mask register that loads together with the pattern. A 0 mask bit makes that bit
// position don't-care.
//
// Parameters:
//   PAT_LEN  pattern length in bits (2..32)
//   PATTERN  pattern active after reset; MSB is compared against the oldest bit
//   OVERLAP  1: overlapping matches allowed; 0: history restarts after each match
//   CNT_W    width of the match counter
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       synchronous active-high reset
//   seqValid  seqIn is sampled on cycles where this is high
//   seqIn     serial data bit
//   patLoad   load patIn (and patMaskIn) as the new pattern; clears the history
//   patIn     new pattern value
//   patMaskIn new compare mask (SEQ_DET_MASK_EN only)
//   cntClr    synchronous clear of detCnt; wins over a coincident match
//   detOut    registered one-cycle detect pulse
//   detCnt    saturating match count
//   armed     history holds PAT_LEN valid bits
module seq_det_param #(
  parameter int unsigned        PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1001,
  parameter bit                 OVERLAP = 1'b1,
  parameter int unsigned        CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seqValid,
  input  logic               seqIn,
  input  logic               patLoad,
  input  logic [PAT_LEN-1:0] patIn,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_LEN-1:0] patMaskIn,
`endif
  input  logic               cntClr,
  output logic               detOut,
  output logic [CNT_W-1:0]   detCnt,
  output logic               armed
);

  // fill counts valid history bits, 0..PAT_LEN inclusive.
  localparam int unsigned       FillW   = $clog2(PAT_LEN + 1);
  localparam logic [FillW-1:0]  FillMax = FillW'(PAT_LEN);
  // A sample can complete the pattern once PAT_LEN-1 bits are already held.
  localparam logic [FillW-1:0]  FillArm = FillW'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] mask_q, mask_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               det_q, det_d;
  logic               armed_q, armed_d;

  logic [PAT_LEN-1:0] nxt;
  logic               pat_eq;
  logic               hit;

  // Without the mask feature the mask register is a constant all-ones, so the compare below is
  // an exact compare and the behaviour matches the masked build with an all-ones mask.
`ifdef SEQ_DET_MASK_EN
  assign mask_d = patLoad ? patMaskIn : mask_q;
`else
  assign mask_d = {PAT_LEN{1'b1}};
`endif

  always_comb begin
    nxt     = {hist_q[PAT_LEN-2:0], seqIn};
    pat_eq  = ((nxt ^ pat_q) & mask_q) == '0;
    // patLoad takes priority over a sample in the same cycle, so that sample can never match.
    hit     = seqValid && !patLoad && (fill_q >= FillArm) && pat_eq;

    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;

    if (patLoad) begin
      pat_d  = patIn;
      hist_d = '0;
      fill_d = '0;
    end else if (seqValid) begin
      hist_d = nxt;
      if (hit && !OVERLAP) begin
        // Non-overlapping: the next match must be built from PAT_LEN fresh bits.
        fill_d = '0;
      end else if (fill_q != FillMax) begin
        fill_d = fill_q + FillW'(1);
      end
    end

    cnt_d = cnt_q;
    if (cntClr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    det_d   = hit;
    armed_d = (fill_d == FillMax);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PATTERN;
      hist_q  <= '0;
      mask_q  <= {PAT_LEN{1'b1}};
      fill_q  <= '0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      mask_q  <= mask_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      armed_q <= armed_d;
    end
  end

  assign detOut = det_q;
  assign detCnt = cnt_q;
  assign armed  = armed_q;

endmodule
